// File: rtl/eeprom_logger_pkg.sv
// Shared definitions for the sample logging path: FSM encoding for the
// EEPROM page writer, default bus widths and the slot count of the timer.
package eeprom_logger_pkg;

  // Default widths for a 32 KiB byte-addressed EEPROM and 8-bit samples.
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 15;

  // The sample timer walks slots 0..SLOT_COUNT-1 and wraps.
  localparam int SLOT_COUNT = 64;

  // Writer FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO. dout shows the head entry
// whenever the FIFO is non-empty. Simultaneous push and pop are both
// honoured, so a push into a full FIFO succeeds when the head is popped
// in the same cycle. flush empties the FIFO.
module sample_fifo
  #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
  )
  (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
  );

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state pointers and occupancy.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves one unassigned infers a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers and count define which entries are valid.
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sample_page_writer.sv
// Captures one sample byte per slot advance of the sample timer into a
// small FIFO and drains it, one byte at a time, to the EEPROM byte-write
// controller over a req/ack handshake with linear addresses. Logging stops
// permanently once MEM_BYTES bytes have been acknowledged.
module sample_page_writer
  import eeprom_logger_pkg::*;
  #(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int MEM_BYTES  = 32768,
    parameter int FIFO_DEPTH = 4
  )
  (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [31:0]       samplecounter,
    input  logic [DATA_W-1:0] sample_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              busy,
    output logic              overrun,
    output logic              full,
    output logic [ADDR_W:0]   bytes_written
  );

  localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

  logic [1:0]        state_q,         state_d;
  logic [31:0]       prev_q;
  logic              wr_req_q,        wr_req_d;
  logic [ADDR_W-1:0] wr_addr_q,       wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,       wr_data_d;
  logic [ADDR_W:0]   bytes_written_q, bytes_written_d;
  logic              overrun_q,       overrun_d;
  logic              full_q,          full_d;

  logic              tick;
  logic              fifo_pop;
  logic              fifo_flush;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;

  // Any change of the slot index is a slot advance, including the wrap to 0.
  assign tick       = enable & ~full_q & (samplecounter != prev_q);
  assign fifo_pop   = (state_q == ST_IDLE) & ~fifo_empty & ~full_q;
  assign fifo_flush = (state_q == ST_STOP);

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tick),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (sample_data),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Sticky overrun: a tick found the FIFO full with no pop freeing a slot.
  assign overrun_d = overrun_q | (tick & fifo_full & ~fifo_pop);

  // Writer FSM: pop a byte, hold the request until acked, pause one cycle.
  always_comb begin
    state_d         = state_q;
    wr_req_d        = wr_req_q;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    bytes_written_d = bytes_written_q;
    full_d          = full_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          wr_data_d = fifo_dout;
          wr_addr_d = bytes_written_q[ADDR_W-1:0];
          wr_req_d  = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          if (bytes_written_q != MEM_LIMIT) bytes_written_d = bytes_written_q + 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bytes_written_q == MEM_LIMIT) begin
          full_d  = 1'b1;
          state_d = ST_STOP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STOP: begin
        state_d = ST_STOP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, handshake and status registers; reset drops wr_req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      prev_q          <= '0;
      wr_req_q        <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      bytes_written_q <= '0;
      overrun_q       <= 1'b0;
      full_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      prev_q          <= samplecounter;
      wr_req_q        <= wr_req_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      bytes_written_q <= bytes_written_d;
      overrun_q       <= overrun_d;
      full_q          <= full_d;
    end
  end

  assign wr_req        = wr_req_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign overrun       = overrun_q;
  assign full          = full_q;
  assign bytes_written = bytes_written_q;
  assign busy          = (fifo_count != '0) | wr_req_q;

endmodule

// File: tb/tb_sample_page_writer.sv
// Scoreboard bench for sample_page_writer. Stimulus predicts the write
// stream (address = order of acceptance, data = captured byte) and pushes
// it into a queue; a monitor pops and compares on each new wr_req; a
// responder acknowledges requests after a random delay.
module tb_sample_page_writer;
  import eeprom_logger_pkg::*;

  localparam int DW = 8;
  localparam int AW = 15;
  localparam int MB = 16;
  localparam int FD = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [31:0]   samplecounter;
  logic [DW-1:0] sample_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          busy;
  logic          overrun;
  logic          full;
  logic [AW:0]   bytes_written;

  always #5 clk = ~clk;

  sample_page_writer #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .MEM_BYTES  (MB),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .samplecounter (samplecounter),
    .sample_data   (sample_data),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .busy          (busy),
    .overrun       (overrun),
    .full          (full),
    .bytes_written (bytes_written)
  );

  wr_t         exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          n_idx  = 0;   // bytes accepted since reset (next write address)
  int          n_acks = 0;   // acknowledged writes since reset
  bit          exp_ovr = 1'b0;
  logic [31:0] cur_sc = '0;
  bit          ack_hold = 1'b0;
  int          ack_min = 0;
  int          ack_max = 4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a slot change with enable high is a sample. The
  // writer holds at most one byte in flight plus FD buffered; a sample
  // arriving with that capacity used is dropped and flags overrun. Bytes
  // beyond the memory size are never written.
  task automatic step(input logic [31:0] sc, input logic [DW-1:0] d, input bit en);
    @(negedge clk);
    if (en && sc != cur_sc) begin
      if (n_idx >= MB) begin
        n_idx++;
      end else if (n_idx - n_acks < 1 + FD) begin
        exp_q.push_back('{addr: AW'(n_idx), data: d});
        n_idx++;
      end else begin
        exp_ovr = 1'b1;
      end
    end
    cur_sc        = sc;
    samplecounter = sc;
    sample_data   = d;
    enable        = en;
  endtask

  task automatic do_reset();
    #2;
    rst           = 1'b1;
    samplecounter = '0;
    sample_data   = '0;
    enable        = 1'b1;
    exp_q.delete();
    n_idx   = 0;
    n_acks  = 0;
    exp_ovr = 1'b0;
    cur_sc  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy || wr_req || wr_ack) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: %0d writes still expected, busy=%0b", exp_q.size(), busy);
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: each new request must match the head of the scoreboard and
  // stay stable until it is acknowledged.
  initial begin
    bit  req_seen;
    bit  have_cur;
    wr_t cur;
    req_seen = 1'b0;
    have_cur = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_seen = 1'b0;
        have_cur = 1'b0;
      end else begin
        if (wr_req && !req_seen) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            have_cur = 1'b0;
            $display("FAIL unexpected_req: addr 0x%0h data 0x%0h, none expected", wr_addr, wr_data);
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            check("wr_addr", 32'(wr_addr), 32'(cur.addr));
            check("wr_data", 32'(wr_data), 32'(cur.data));
          end
        end else if (wr_req && have_cur) begin
          check("wr_addr_stable", 32'(wr_addr), 32'(cur.addr));
          check("wr_data_stable", 32'(wr_data), 32'(cur.data));
        end
        req_seen = wr_req;
      end
    end
  end

  // Responder: one-cycle ack after a random delay, unless held off.
  initial begin
    int  d;
    int  waited;
    bit  lost;
    wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_req && !rst) begin
        d      = $urandom_range(ack_max, ack_min);
        waited = 0;
        lost   = 1'b0;
        while (!lost && (ack_hold || waited < d)) begin
          @(negedge clk);
          if (!ack_hold) waited++;
          if (!wr_req || rst) lost = 1'b1;
        end
        if (!lost) begin
          wr_ack = 1'b1;
          @(negedge clk);
          wr_ack = 1'b0;
          n_acks++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] nsc;
    int          t;

    rst           = 1'b1;
    enable        = 1'b0;
    samplecounter = '0;
    sample_data   = '0;
    repeat (2) @(negedge clk);
    check("rst_wr_req",  32'(wr_req), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_full",    32'(full), 0);
    check("rst_bytes",   32'(bytes_written), 0);
    check("rst_busy",    32'(busy), 0);
    enable = 1'b1;
    rst    = 1'b0;
    repeat (2) @(negedge clk);
    check("no_tick_after_rst", 32'(busy), 0);

    // Basic write with latency check: push at N, request visible after N+1.
    ack_min = 2;
    ack_max = 2;
    step(1, 8'hA5, 1'b1);
    @(negedge clk);
    check("lat_req_after_push", 32'(wr_req), 0);
    check("lat_busy_after_push", 32'(busy), 1);
    @(negedge clk);
    check("lat_req_after_pop", 32'(wr_req), 1);
    wait_drain();
    check("basic_bytes", 32'(bytes_written), 1);
    check("basic_busy", 32'(busy), 0);

    // Slot wrap 63 -> 0 is a tick.
    step(SLOT_COUNT - 1, 8'h11, 1'b1);
    step(0, 8'h3C, 1'b1);
    wait_drain();
    check("wrap_bytes", 32'(bytes_written), 3);

    // Enable gating and an unchanged slot index.
    step(5, 8'h55, 1'b0);
    step(6, 8'h66, 1'b0);
    step(6, 8'h99, 1'b1);
    repeat (3) @(negedge clk);
    check("gate_wr_req", 32'(wr_req), 0);
    check("gate_busy", 32'(busy), 0);
    check("gate_bytes", 32'(bytes_written), 3);

    // Back-pressure: six samples with no acks; the sixth is dropped.
    do_reset();
    ack_hold = 1'b1;
    ack_min  = 0;
    ack_max  = 3;
    for (int i = 1; i <= 6; i++) begin
      step(32'(i), DW'(i), 1'b1);
      @(negedge clk);
    end
    check("bp_overrun", 32'(overrun), 32'(exp_ovr));
    check("bp_busy", 32'(busy), 1);
    check("bp_wr_req", 32'(wr_req), 1);
    check("bp_bytes", 32'(bytes_written), 0);
    ack_hold = 1'b0;
    wait_drain();
    check("bp_bytes_after", 32'(bytes_written), 5);
    check("bp_overrun_sticky", 32'(overrun), 1);

    // Randomized logging up to one byte short of the memory size.
    do_reset();
    ack_max = 4;
    for (int it = 0; it < 600 && n_idx < MB - 1; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (n_idx - n_acks <= 3) begin
        case ($urandom_range(0, 2))
          0:       nsc = cur_sc;
          1:       nsc = (cur_sc + 1) % SLOT_COUNT;
          default: nsc = $urandom_range(0, SLOT_COUNT - 1);
        endcase
        step(nsc, DW'($urandom), $urandom_range(0, 3) != 0);
      end else begin
        @(negedge clk);
      end
    end
    wait_drain();
    check("rand_bytes", 32'(bytes_written), 32'(n_acks));
    check("rand_overrun", 32'(overrun), 0);
    check("rand_full", 32'(full), 0);

    // Last byte held in flight while two more samples queue behind it;
    // those are discarded once memory is full.
    ack_hold = 1'b1;
    step((cur_sc + 1) % SLOT_COUNT, 8'hE7, 1'b1);
    repeat (3) @(negedge clk);
    step((cur_sc + 1) % SLOT_COUNT, 8'hB1, 1'b1);
    step((cur_sc + 1) % SLOT_COUNT, 8'hB2, 1'b1);
    ack_hold = 1'b0;
    wait_drain();
    check("full_flag", 32'(full), 1);
    check("full_bytes", 32'(bytes_written), MB);
    check("full_busy", 32'(busy), 0);
    check("full_overrun", 32'(overrun), 0);
    for (int i = 0; i < 4; i++) begin
      step((cur_sc + 1) % SLOT_COUNT, DW'(8'hC0 + i), 1'b1);
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("stop_wr_req", 32'(wr_req), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_bytes", 32'(bytes_written), MB);
    check("stop_overrun", 32'(overrun), 0);

    // Reset while a request is pending drops it asynchronously.
    do_reset();
    check("rst_clears_full", 32'(full), 0);
    ack_hold = 1'b1;
    step(9, 8'h77, 1'b1);
    t = 0;
    while (!wr_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("midreq_req_seen", 32'(wr_req), 1);
    #2;
    rst = 1'b1;
    #1;
    check("midreq_wr_req", 32'(wr_req), 0);
    check("midreq_bytes", 32'(bytes_written), 0);
    check("midreq_busy", 32'(busy), 0);
    do_reset();
    ack_hold = 1'b0;
    step(10, 8'h88, 1'b1);
    wait_drain();
    check("midreq_after_bytes", 32'(bytes_written), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sample_page_writer.md
Name: sample_page_writer

Overview:
- Consumer of the 0..63 slot counter produced by the sample-timing stage.
- On each slot advance, captures one sample byte into a 4-entry FIFO and drains it to the EEPROM byte-write controller over a req/ack handshake.
- Generates linear EEPROM addresses; one slot period (about 7 ms) covers the EEPROM write cycle time.
- Sits between the sample timer/ADC front end and the EEPROM bus controller.

Parameters:
- DATA_W, 8, width of sample and write data.
- ADDR_W, 15, EEPROM byte-address width (32 KiB part).
- MEM_BYTES, 32768, number of bytes to log before stopping. Must be ≤ 2^ADDR_W.
- FIFO_DEPTH, 4, sample buffer entries. Must be a power of two.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  logging enable. When low, slot advances are ignored.
- samplecounter  in  32  slot index from the sample timer (0..63, wraps).
- sample_data  in  DATA_W  current sample byte.
- wr_req  out  1  write request to the EEPROM controller.
- wr_addr  out  ADDR_W  byte address. Valid while wr_req is high.
- wr_data  out  DATA_W  byte to write. Valid while wr_req is high.
- wr_ack  in  1  controller completion strobe.
- busy  out  1  high when the FIFO is non-empty or wr_req is high.
- overrun  out  1  sticky: a sample was dropped because the FIFO was full.
- full  out  1  high once MEM_BYTES bytes have been written.
- bytes_written  out  ADDR_W+1  count of acknowledged writes.

Behaviour:
- Reset (async, rst=1):
  - wr_req=0, wr_addr=0, wr_data=0, overrun=0, full=0, bytes_written=0.
  - FIFO empty; prev_q=0; FSM=IDLE.
  - A reset during a pending request drops wr_req immediately. No write is counted.
- Tick detect:
  - tick = enable & ~full & (samplecounter != prev_q).
  - prev_q <= samplecounter on every clock, regardless of enable.
  - Any change counts, including the 63→0 wrap. No tick on the first cycle after reset when samplecounter is 0.
- Capture: on a tick edge, sample_data is pushed into the FIFO. If the FIFO is full, nothing is pushed and overrun is set. overrun clears only on reset.
- FSM states:
  - IDLE: if the FIFO is non-empty and ~full, pop it, load wr_data with the popped byte and wr_addr with bytes_written[ADDR_W-1:0], then go to REQ.
  - REQ: wr_req=1 with wr_addr/wr_data held stable. When wr_ack=1 is sampled: wr_req<=0, bytes_written += 1, go to DONE.
  - DONE: one-cycle gap with wr_req=0. If bytes_written==MEM_BYTES, set full and go to STOP; otherwise go to IDLE.
  - STOP: terminal until reset. Ticks are ignored and overrun is not set. Any residual FIFO entries are discarded.
- Handshake rules:
  - wr_ack outside REQ is ignored.
  - wr_req stays high indefinitely until acknowledged. There is no timeout.
- Latency: a samplecounter change visible before edge N gives a push at edge N, IDLE pops at edge N+1, and wr_req is high after edge N+1.
- Push and pop in the same cycle are both performed. Count stays the same; an overrun is not raised when the FIFO was full but popping that cycle.
- Widths and wrap:
  - bytes_written saturates at MEM_BYTES and never wraps.
  - wr_addr equals the lower ADDR_W bits of bytes_written at pop time.
- busy is combinational: (fifo_count != 0) | wr_req.

Decomposition:
- Shared package (eeprom_logger_pkg) holds:
  - FSM state encoding (IDLE, REQ, DONE, STOP).
  - DATA_W and ADDR_W defaults.
  - Slot count of 64.
- One sub-module: sample_fifo, a synchronous FIFO parameterised by width and depth.
  - Inputs: push, pop.
  - Outputs: dout, empty, full, count.
  - Reset: async, active-high.

Test Plan:
- Basic write: step samplecounter 0→1 with sample_data=0xA5, then ack after 3 cycles. Expect wr_req high 2 cycles after the change, wr_addr=0, wr_data=0xA5, bytes_written=1, and busy low afterwards.
- Wrap tick: step samplecounter 63→0 with data 0x3C. Expect a write to occur at the next sequential address.
- Back-pressure / overrun: hold wr_ack=0 and issue 6 ticks with data 1..6. Expect bytes 1..5 retained (1 in flight plus 4 in the FIFO), byte 6 dropped and overrun=1. After acking, expect the write sequence 1,2,3,4,5 at addresses 0..4.
- Enable gating: with enable=0, step samplecounter 5→6. Expect no push and no wr_req.
- Memory full: with MEM_BYTES=4, run 6 ticks, each acked. Expect exactly 4 writes (addresses 0..3), full=1, bytes_written=4, no further wr_req, and overrun=0.
- Reset mid-request: assert rst while wr_req=1. Expect wr_req=0 asynchronously and all counters 0. After release, expect a new tick to write to address 0.
